// File: rtl/osc_clkgen_multi.sv
// osc_clkgen_multi
// Derives NCH glitch-free 50%-duty clocks from one reference clock.
// Each channel has its own programmable divide ratio. All channels share
// the enable/supply qualifiers, a settle-then-ready start-up sequence and a
// sticky supply-loss fault flag. Every output comes straight from a flop.

module osc_clkgen_multi #(
    parameter int NCH    = 2,
    parameter int DIVW   = 8,
    parameter int SETTLE = 16
) (
    input  logic                 id_clk,
    input  logic                 id_rst,
    input  logic                 id_en,
    input  logic                 id_supply_ok,
    input  logic [NCH*DIVW-1:0]  id_div,
    input  logic                 id_load,
    output logic [NCH-1:0]       od_clk,
    output logic                 od_ready,
    output logic                 od_fault
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_RUN,
        ST_STOP
    } state_t;

    localparam int CW = $clog2(SETTLE + 1);

    state_t            state;
    logic [CW-1:0]     settle_cnt;
    logic [DIVW-1:0]   phase      [NCH];
    logic [DIVW-1:0]   act_ratio  [NCH];
    logic [DIVW-1:0]   pend_ratio [NCH];
    logic [DIVW-1:0]   div_slice  [NCH];
    logic [NCH-1:0]    at_end;
    logic              stopping;

    // Split the packed ratio bus into channels and flag each channel whose phase
    // counter sits at its last count (R-1, with a raw ratio of 0 treated as 1).
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            div_slice[k] = id_div[k*DIVW +: DIVW];
            at_end[k]    = (phase[k] == ((act_ratio[k] == '0) ? DIVW'(0)
                                                              : act_ratio[k] - DIVW'(1)));
        end
        stopping = (state == ST_STOP) || !id_en;
    end

    // Main sequencer. It handles the state machine, the per-channel dividers,
    // ratio loading, and the ready/fault flags. Everything is registered here.
    always_ff @(posedge id_clk) begin
        if (id_rst) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            od_clk     <= '0;
            od_ready   <= 1'b0;
            od_fault   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                phase[k]      <= '0;
                act_ratio[k]  <= DIVW'(1);
                pend_ratio[k] <= DIVW'(1);
            end
        end else begin
            if (id_load) begin
                for (int k = 0; k < NCH; k++) begin
                    pend_ratio[k] <= div_slice[k];
                end
            end

            case (state)
                ST_OFF: begin
                    od_clk   <= '0;
                    od_ready <= 1'b0;
                    for (int k = 0; k < NCH; k++) begin
                        phase[k]     <= '0;
                        act_ratio[k] <= id_load ? div_slice[k] : pend_ratio[k];
                    end
                    if (id_en && id_supply_ok && !od_fault) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end

                ST_SETTLE: begin
                    if (!id_en || !id_supply_ok) begin
                        state      <= ST_OFF;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CW'(SETTLE - 1)) begin
                        state      <= ST_RUN;
                        settle_cnt <= '0;
                        od_clk     <= '1;
                        od_ready   <= 1'b1;
                        for (int k = 0; k < NCH; k++) begin
                            phase[k] <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end

                ST_RUN, ST_STOP: begin
                    if (!id_supply_ok) begin
                        state      <= ST_OFF;
                        settle_cnt <= '0;
                        od_clk     <= '0;
                        od_ready   <= 1'b0;
                        od_fault   <= 1'b1;
                        for (int k = 0; k < NCH; k++) begin
                            phase[k] <= '0;
                        end
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            if (od_clk[k] && at_end[k]) begin
                                od_clk[k]    <= 1'b0;
                                phase[k]     <= '0;
                                act_ratio[k] <= pend_ratio[k];
                            end else if (od_clk[k]) begin
                                phase[k] <= phase[k] + DIVW'(1);
                            end else if (stopping) begin
                                phase[k] <= '0;
                            end else if (at_end[k]) begin
                                od_clk[k] <= 1'b1;
                                phase[k]  <= '0;
                            end else begin
                                phase[k] <= phase[k] + DIVW'(1);
                            end
                        end
                        if (state == ST_RUN && !id_en) begin
                            state    <= ST_STOP;
                            od_ready <= 1'b0;
                        end else if (state == ST_STOP && od_clk == '0) begin
                            state <= ST_OFF;
                        end
                    end
                end

                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: doc/osc_clkgen_multi.md
Name: osc_clkgen_multi

Overview:
- Parametrised digital successor to the single-output enable-gated oscillator model.
- Derives NCH independent, glitch-free, 50%-duty clocks from one reference clock.
- Each channel has a programmable divide ratio; all channels share an enable and supply-good qualifier.
- Provides a settle-then-ready sequence and a fault flag for supply loss.
- Sits between the reference oscillator and downstream digital consumers of the divided clocks.

Parameters:
NCH, 2, number of output clock channels (1..8)
DIVW, 8, width of each channel's divide-ratio field
SETTLE, 16, id_clk cycles with id_en and id_supply_ok high before outputs start (>=1)

Ports:
id_clk  input  1  reference clock; all logic is on its rising edge
id_rst  input  1  synchronous reset, active-high
id_en  input  1  generator enable
id_supply_ok  input  1  supply-good qualifier; must be 1 for the generator to run
id_div  input  NCH*DIVW  divide ratio per channel; channel k uses bits [k*DIVW +: DIVW]
id_load  input  1  one-cycle strobe that captures id_div into the per-channel pending registers
od_clk  output  NCH  divided clocks
od_ready  output  1  high while all channels are running
od_fault  output  1  sticky flag, set on supply loss while running

Behaviour:
- Reset (id_rst=1 at a rising edge):
  - od_clk=0, od_ready=0, od_fault=0, state=OFF.
  - Settle counter = 0.
  - Active and pending ratios for every channel = 1.
- Ratio rule:
  - Effective ratio R = max(D,1); D=0 is treated as 1.
  - Channel period = 2R id_clk cycles: high for R cycles, low for R cycles.
  - Per-channel phase counter is DIVW bits wide and counts 0..R-1.
  - At R-1 the output toggles and the counter wraps to 0.
- id_load:
  - Captures id_div into the pending registers on the same edge, in any state.
  - A pending ratio becomes active only on the edge where that channel's od_clk goes 1->0; the new ratio governs the following low phase.
  - In OFF, a captured ratio is applied immediately.
  - Strobing id_load again before the pending ratio is applied overwrites the pending ratio.
- States: OFF, SETTLE, RUN, STOP.
  - OFF -> SETTLE: id_en & id_supply_ok & !od_fault. Settle counter cleared.
  - SETTLE:
    - Counter increments each cycle.
    - Leaving either id_en or id_supply_ok low returns to OFF with the counter cleared.
    - When the counter reaches SETTLE-1 -> RUN. Phase counters are 0; od_clk rises on the first RUN edge.
    - od_ready is set on the same edge as that first rise.
  - RUN:
    - Channels free-run.
    - id_en=0 -> STOP; od_ready cleared on that edge.
  - STOP:
    - Each channel completes its current high phase.
    - After its 1->0 transition the channel holds low with its phase counter frozen at 0.
    - Channels that are already low stop immediately.
    - When all od_clk are 0 -> OFF.
    - id_en reasserting while in STOP has no effect until OFF is reached.
- Supply loss (id_supply_ok=0 in RUN or STOP):
  - Next edge: all od_clk=0 immediately (truncated pulse permitted), od_ready=0, od_fault=1, state -> OFF.
  - od_fault is sticky; only id_rst clears it.
  - While od_fault=1, OFF does not leave.
- Priority: id_rst > supply loss > id_en deassert > normal counting.
- Reset asserted mid-RUN forces the reset values on that edge; no completion of the current phase.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. NCH=2, div={3,1}, id_en=1, supply_ok=1 after reset
   - od_ready rises 16 cycles after id_en.
   - ch0 shows 3 high / 3 low; ch1 toggles every cycle; both rise together on the first RUN edge.
2. RUN with ch0 at ratio 3, id_load with ch0=5 mid high phase
   - Current high phase stays 3 cycles.
   - Following low phase and all later phases are 5 cycles; no short pulse.
3. ch0 ratio 4, id_en dropped 1 cycle into a high phase
   - od_ready falls the next edge.
   - ch0 completes its 4-cycle high, then holds 0.
   - State reaches OFF once all channels are low; the re-enable path then requires a fresh 16-cycle settle.
4. id_supply_ok dropped for 1 cycle during RUN
   - Next edge: od_clk=0, od_ready=0, od_fault=1.
   - A later id_en toggle does not restart; id_rst clears od_fault and the generator restarts after settle.
5. div=0 on a channel
   - Behaves as ratio 1 (period 2).
   - id_supply_ok low at SETTLE count 10 -> OFF, counter cleared; the restart requires the full 16 cycles.
6. id_rst asserted mid high phase in RUN
   - All outputs 0 on that edge.
   - Ratios revert to 1 until a new id_load.
